serial_sub: RTL and testbench

//  Bit-serial unsigned subtractor: diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.

---
 rtl/arith_pkg.sv | 16 +
 rtl/full_sub.sv | 13 +
 rtl/serial_sub.sv | 104 ++++++++++
 tb/tb_serial_sub.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: control state
// encodings and the iteration-counter width helper.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Counter must hold 0..w; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w < 1) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: di = a - b - c, bor = borrow out.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic di,
   output logic bor
);

   assign di  = a ^ b ^ c;
   assign bor = (b & c) | (~a & c) | (~a & b);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first: diff = a - b - bin over WIDTH bits,
// one bit per clock, with a start/busy/done handshake.
module serial_sub
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic             borrow;
   logic [CW-1:0]    count;

   logic             cell_d;
   logic             cell_bo;
   logic [WIDTH-1:0] diff_next;

   full_sub u_cell (
      .di  (cell_d),
      .bor (cell_bo),
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .c   (borrow)
   );

   // New result bit enters at the MSB; written this way so WIDTH=1 also works.
   always_comb begin
      diff_next            = diff_sr >> 1;
      diff_next[WIDTH-1]   = cell_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         borrow  <= 1'b0;
         count   <= '0;
      end else begin
         // NOTE: done defaults low every edge so it can only ever be a one-cycle pulse.
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               borrow  <= cell_bo;
               diff_sr <= diff_next;
               count   <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  diff  <= diff_next;
                  bout  <= cell_bo;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done <= 1'b1;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= ST_SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: WIDTH=8 and WIDTH=1 instances, directed table,
// multi-cycle corner sequences and random operands against an arithmetic model.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       bin1 = 1'b0;
   logic       busy1, done1, bout1;
   logic [0:0] diff1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_sub #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain unsigned arithmetic on the operands.
   function automatic logic [8:0] model8(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
      int r;
      r = int'(ma) - int'(mb) - int'(mbin);
      return {r < 0, 8'(r + 256)};
   endfunction

   task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic eb, input string tag);
      int n;
      @(negedge clk);
      a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check({tag, " busy after start"}, busy8, 1);
      check({tag, " no done at start"}, done8, 0);
      n = 0;
      while (!done8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, n, 9);
      check({tag, " diff"}, diff8, ed);
      check({tag, " bout"}, bout8, eb);
      check({tag, " busy at done"}, busy8, 0);
      repeat (2) @(posedge clk);
      #1;
      check({tag, " done one cycle"}, done8, 0);
      check({tag, " diff held"}, {bout8, diff8}, {eb, ed});
   endtask

   task automatic do_op1(input logic ta, input logic tb, input logic tbin, input string tag);
      int n;
      int r;
      r = int'(ta) - int'(tb) - int'(tbin);
      @(negedge clk);
      a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, n, 2);
      check({tag, " diff"}, diff1, r & 1);
      check({tag, " bout"}, bout1, r < 0);
      check({tag, " busy at done"}, busy1, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[7];
      logic [7:0] ra, rb, cap_a, cap_b;
      logic       rbin, cap_bin;
      logic [8:0] m;
      int         n;

      vt[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
      vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vt[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
      vt[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
      vt[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vt[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
      vt[6] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0};

      // Reset values
      #12;
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset diff8", diff8, 0);
      check("reset bout8", bout8, 0);
      check("reset w1 outs", {busy1, done1, diff1, bout1}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         do_op8(vt[i].a, vt[i].b, vt[i].bin, vt[i].diff, vt[i].bout, $sformatf("vec%0d", i));

      // start held through SHIFT with changing operands, then into DONE (back-to-back)
      @(negedge clk);
      a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
      cap_a = '0; cap_b = '0; cap_bin = 1'b0;
      @(posedge clk); #1;
      for (int e = 1; e <= 18; e++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         start8 = (e <= 9);
         if (e == 9) begin
            cap_a = a8; cap_b = b8; cap_bin = bin8;
         end
         @(posedge clk); #1;
         if (e == 9) begin
            check("b2b first done", done8, 1);
            check("b2b first result", {bout8, diff8}, {1'b0, 8'h23});
         end else if (e == 18) begin
            m = model8(cap_a, cap_b, cap_bin);
            check("b2b second done", done8, 1);
            check("b2b second result", {bout8, diff8}, m);
            check("b2b busy low", busy8, 0);
         end else begin
            check($sformatf("b2b no done e%0d", e), done8, 0);
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(posedge clk);

      // Reset asserted at the 4th SHIFT edge aborts the operation
      do_op8(8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, "pre-abort");
      @(negedge clk);
      a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("abort busy", busy8, 0);
      check("abort diff", diff8, 0);
      check("abort bout", bout8, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done8 || busy8) n++;
      end
      check("abort no done/busy after release", n, 0);
      do_op8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, "post-abort");

      // WIDTH=1 truth table
      for (int k = 0; k < 8; k++)
         do_op1(k[2], k[1], k[0], $sformatf("w1 combo%0d", k));

      // Random operands against the arithmetic model
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         m = model8(ra, rb, rbin);
         do_op8(ra, rb, rbin, m[7:0], m[8], $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
